// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I opcode, state and mux-select encodings
// for the multi-cycle core control path.
package rv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_DEC   = 3'd1,
    ST_EXE   = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_TRAP  = 3'd5
  } state_e;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  function automatic logic opc_legal(
    input logic [6:0] op
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (op == OPC_OP),
      (op == OPC_OPIMM),
      (op == OPC_LUI),
      (op == OPC_AUIPC),
      (op == OPC_LOAD),
      (op == OPC_STORE),
      (op == OPC_BRANCH),
      (op == OPC_JAL),
      (op == OPC_JALR): ok = 1'b1;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer
// for the multi-cycle RV32I core, with retired-instruction counter.
module multi_cycle_ctrl
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        imem_req,
  output logic        ir_load,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        alu_src_b,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instret
);

  state_e      state_q, state_d;
  logic [6:0]  op_q, op_d;
  logic        illegal_q, illegal_d;
  logic [31:0] instret_q, instret_d;
  logic        retire;

  // State, latched opcode, sticky trap flag and retire counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      op_q      <= 7'd0;
      illegal_q <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  // Next-state sequencing and retire detection
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) state_d = ST_DEC;
      end
      ST_DEC: begin
        op_d = opcode;
        if (opc_legal(opcode)) begin
          state_d = ST_EXE;
        end else begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end
      end
      ST_EXE: begin
        unique case (1'b1)
          (op_q == OPC_LOAD),
          (op_q == OPC_STORE): state_d = ST_MEM;
          (op_q == OPC_BRANCH): begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (op_q == OPC_STORE) begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
    instret_d = instret_q + {31'd0, retire};
  end

  // Strobes and mux selects decoded from state and latched opcode
  always_comb begin
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    alu_src_b = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_load  = mem_ready;
        pc_write = mem_ready;
      end
      ST_EXE: begin
        unique case (1'b1)
          (op_q == OPC_OPIMM),
          (op_q == OPC_LUI),
          (op_q == OPC_AUIPC),
          (op_q == OPC_LOAD),
          (op_q == OPC_STORE): alu_src_b = 1'b1;
          (op_q == OPC_BRANCH): begin
            pc_write = branch_taken;
            pc_src   = PC_TARGET;
          end
          (op_q == OPC_JAL): begin
            pc_write = 1'b1;
            pc_src   = PC_TARGET;
          end
          (op_q == OPC_JALR): begin
            pc_write = 1'b1;
            pc_src   = PC_JALR;
          end
          default: alu_src_b = 1'b0;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OPC_STORE);
      end
      ST_WB: begin
        reg_write = 1'b1;
        unique case (1'b1)
          (op_q == OPC_LOAD): wb_sel = WB_MEM;
          (op_q == OPC_JAL),
          (op_q == OPC_JALR): wb_sel = WB_PC4;
          default:            wb_sel = WB_ALU;
        endcase
      end
      default: ;
    endcase
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: cycle-by-cycle vector table for the
// sequencer plus directed trap, counter-wrap and reset sequences.
module tb_multi_cycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        mem_ready;
  logic        imem_req, ir_load, pc_write;
  logic [1:0]  pc_src;
  logic        alu_src_b, dmem_req, dmem_we, reg_write;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] instret;

  multi_cycle_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .imem_req     (imem_req),
    .ir_load      (ir_load),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .alu_src_b    (alu_src_b),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .state        (state),
    .illegal      (illegal),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  // strobe bits: imem ir pcw pcsrc[2] alub dreq dwe rw wb[2]
  logic [10:0] strb;
  assign strb = {imem_req, ir_load, pc_write, pc_src,
                 alu_src_b, dmem_req, dmem_we,
                 reg_write, wb_sel};

  localparam logic [10:0] FE_GO   = 11'b1_1_1_00_0_0_0_0_00;
  localparam logic [10:0] FE_WAIT = 11'b1_0_0_00_0_0_0_0_00;
  localparam logic [10:0] NONE    = 11'b0_0_0_00_0_0_0_0_00;
  localparam logic [10:0] EX_IMM  = 11'b0_0_0_00_1_0_0_0_00;
  localparam logic [10:0] EX_JAL  = 11'b0_0_1_01_0_0_0_0_00;
  localparam logic [10:0] EX_JALR = 11'b0_0_1_10_0_0_0_0_00;
  localparam logic [10:0] EX_BRN  = 11'b0_0_0_01_0_0_0_0_00;
  localparam logic [10:0] MEM_LD  = 11'b0_0_0_00_0_1_0_0_00;
  localparam logic [10:0] MEM_ST  = 11'b0_0_0_00_0_1_1_0_00;
  localparam logic [10:0] WB_A    = 11'b0_0_0_00_0_0_0_1_00;
  localparam logic [10:0] WB_L    = 11'b0_0_0_00_0_0_0_1_01;
  localparam logic [10:0] WB_J    = 11'b0_0_0_00_0_0_0_1_10;

  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] BAD  = 7'b1111111;

  typedef struct {
    logic [6:0]  op;
    logic        mr;
    logic        bt;
    logic [2:0]  st;
    logic [10:0] s;
    logic [31:0] n;
  } vec_t;

  vec_t vt[64];
  int   nv = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic add(input logic [6:0] op, input logic mr,
                     input logic bt, input logic [2:0] st,
                     input logic [10:0] s, input logic [31:0] n);
    vt[nv] = '{op, mr, bt, st, s, n};
    nv++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = ADD;
    branch_taken = 1'b0;
    mem_ready = 1'b0;

    // ADD
    add(ADD, 1, 0, 0, FE_GO, 0);
    add(ADD, 1, 0, 1, NONE, 0);
    add(ADD, 1, 0, 2, NONE, 0);
    add(ADD, 1, 0, 4, WB_A, 0);
    // ADDI
    add(ADDI, 1, 0, 0, FE_GO, 1);
    add(ADDI, 1, 0, 1, NONE, 1);
    add(ADDI, 1, 0, 2, EX_IMM, 1);
    add(ADDI, 1, 0, 4, WB_A, 1);
    // LUI
    add(LUI, 1, 0, 0, FE_GO, 2);
    add(LUI, 1, 0, 1, NONE, 2);
    add(LUI, 1, 0, 2, EX_IMM, 2);
    add(LUI, 1, 0, 4, WB_A, 2);
    // JAL
    add(JAL, 1, 0, 0, FE_GO, 3);
    add(JAL, 1, 0, 1, NONE, 3);
    add(JAL, 1, 0, 2, EX_JAL, 3);
    add(JAL, 1, 0, 4, WB_J, 3);
    // JALR
    add(JALR, 1, 0, 0, FE_GO, 4);
    add(JALR, 1, 0, 1, NONE, 4);
    add(JALR, 1, 0, 2, EX_JALR, 4);
    add(JALR, 1, 0, 4, WB_J, 4);
    // branch taken
    add(BEQ, 1, 1, 0, FE_GO, 5);
    add(BEQ, 1, 1, 1, NONE, 5);
    add(BEQ, 1, 1, 2, EX_JAL, 5);
    // branch not taken
    add(BEQ, 1, 0, 0, FE_GO, 6);
    add(BEQ, 1, 0, 1, NONE, 6);
    add(BEQ, 1, 0, 2, EX_BRN, 6);
    // load, two wait cycles in MEMORY
    add(LW, 1, 0, 0, FE_GO, 7);
    add(LW, 0, 0, 1, NONE, 7);
    add(LW, 0, 0, 2, EX_IMM, 7);
    add(LW, 0, 0, 3, MEM_LD, 7);
    add(LW, 0, 0, 3, MEM_LD, 7);
    add(LW, 1, 0, 3, MEM_LD, 7);
    add(LW, 1, 0, 4, WB_L, 7);
    // store, one fetch wait cycle
    add(SW, 0, 0, 0, FE_WAIT, 8);
    add(SW, 1, 0, 0, FE_GO, 8);
    add(SW, 1, 0, 1, NONE, 8);
    add(SW, 1, 0, 2, EX_IMM, 8);
    add(SW, 1, 0, 3, MEM_ST, 8);
    add(ADD, 0, 0, 0, FE_WAIT, 9);
    add(ADD, 0, 0, 0, FE_WAIT, 9);

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_state", {29'd0, state}, 0);
    chk("rst_strobes", {21'd0, strb}, {21'd0, FE_WAIT});
    chk("rst_illegal", {31'd0, illegal}, 0);
    chk("rst_instret", instret, 0);
    rst_n = 1'b1;

    for (int i = 0; i < nv; i++) begin
      opcode       = vt[i].op;
      mem_ready    = vt[i].mr;
      branch_taken = vt[i].bt;
      #1;
      chk($sformatf("v%0d_state", i), {29'd0, state},
          {29'd0, vt[i].st});
      chk($sformatf("v%0d_strb", i), {21'd0, strb},
          {21'd0, vt[i].s});
      chk($sformatf("v%0d_instret", i), instret, vt[i].n);
      @(negedge clk);
    end

    // illegal opcode -> TRAP, held until reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    opcode = BAD;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("trap_dec", {29'd0, state}, 1);
    @(negedge clk);
    chk("trap_state", {29'd0, state}, 5);
    chk("trap_illegal", {31'd0, illegal}, 1);
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      opcode = ADD;
      #1;
      chk($sformatf("trap_hold%0d", i),
          {28'd0, illegal, state}, {28'd0, 1'b1, 3'd5});
      chk($sformatf("trap_strb%0d", i), {21'd0, strb}, 0);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("trap_clr_ill", {31'd0, illegal}, 0);
    chk("trap_clr_st", {29'd0, state}, 0);
    chk("trap_clr_imem", {31'd0, imem_req}, 1);
    rst_n = 1'b1;

    // instret wrap on a store retire
    opcode = SW;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    chk("wrap_pre", instret, 32'hFFFF_FFFF);
    chk("wrap_dmem_we", {31'd0, dmem_we}, 1);
    chk("wrap_mem_st", {29'd0, state}, 3);
    @(negedge clk);
    chk("wrap_post", instret, 0);
    chk("wrap_fetch", {29'd0, state}, 0);

    // one ADD retire, then reset during a load MEMORY wait
    opcode = ADD;
    repeat (4) @(negedge clk);
    chk("add_retire", instret, 1);
    opcode = LW;
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("midrst_dreq", {31'd0, dmem_req}, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_state", {29'd0, state}, 0);
    chk("midrst_dreq0", {31'd0, dmem_req}, 0);
    chk("midrst_instret", instret, 0);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
